// File: rtl/uart_rx.sv
// UART receiver: start, WIDTH data bits LSB-first, even parity, stop.
// Define UART_RX_VALID_EN to add the RX_valid one-cycle frame-done pulse.
module uart_rx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_data,
  output logic             parity_bit_err,
  output logic             stop_bit_err,
`ifdef UART_RX_VALID_EN
  output logic             RX_valid,
`endif
  output logic [WIDTH-1:0] RX_data_out
);

  localparam int unsigned Mid  = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CntW-1:0] CntMid  = CntW'(Mid);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             perr_q, perr_d;
  logic             serr_q, serr_d;
  logic             valid_d;
  logic             at_mid, at_last;

  assign at_mid  = (cnt_q == CntMid);
  assign at_last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = at_last ? '0 : cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    serr_d  = serr_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!RX_data) begin
          // The start-detect edge is slot 0 cycle 0; with one clk per bit the slot is over.
          if (CLKS_PER_BIT == 1) begin
            state_d = StData;
          end else begin
            state_d = StStart;
            cnt_d   = CntW'(1);
          end
        end
      end
      StStart: begin
        if (at_mid && RX_data) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_mid) begin
          shift_d            = shift_q >> 1;
          shift_d[WIDTH-1]   = RX_data;
        end
        if (at_last) begin
          if (idx_q == IdxLast) begin
            state_d = StParity;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (at_mid) par_d = RX_data;
        if (at_last) state_d = StStop;
      end
      StStop: begin
        if (at_mid) begin
          data_d  = shift_q;
          perr_d  = ^{shift_q, par_q};
          serr_d  = ~RX_data;
          valid_d = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
    end
  end

`ifdef UART_RX_VALID_EN
  logic valid_q;

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign RX_valid = valid_q;
`else
  logic unused_valid;
  assign unused_valid = valid_d;
`endif

  assign RX_data_out    = data_q;
  assign parity_bit_err = perr_q;
  assign stop_bit_err   = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at one and four clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1, rx2;
  logic [7:0] dout1, dout2;
  logic       perr1, serr1, perr2, serr2;
`ifdef UART_RX_VALID_EN
  logic       valid1, valid2;
`endif

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .RX_data        (rx1),
    .parity_bit_err (perr1),
    .stop_bit_err   (serr1),
`ifdef UART_RX_VALID_EN
    .RX_valid       (valid1),
`endif
    .RX_data_out    (dout1)
  );

  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .RX_data        (rx2),
    .parity_bit_err (perr2),
    .stop_bit_err   (serr2),
`ifdef UART_RX_VALID_EN
    .RX_valid       (valid2),
`endif
    .RX_data_out    (dout2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: word as sent, even-parity error, inverted stop bit.
  function automatic logic model_perr(input logic [7:0] d, input logic p);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return ((ones + p) % 2) != 0;
  endfunction

  task automatic drive1(input logic b);
    @(negedge clk);
    rx1 = b;
  endtask

  task automatic send1(input logic [7:0] d, input logic p, input logic s);
    drive1(1'b0);
    for (int i = 0; i < 8; i++) drive1(d[i]);
    drive1(p);
    drive1(s);
  endtask

  task automatic frame1(input string tag, input logic [7:0] d, input logic p, input logic s);
    @(posedge clk);
    #1;
    check({tag, "_data"}, dout1, d);
    check({tag, "_perr"}, perr1, model_perr(d, p));
    check({tag, "_serr"}, serr1, !s);
`ifdef UART_RX_VALID_EN
    check({tag, "_valid"}, valid1, 1'b1);
`endif
  endtask

  task automatic drive2(input logic b);
    @(negedge clk);
    rx2 = b;
    repeat (3) @(negedge clk);
  endtask

  task automatic send2(input logic [7:0] d, input logic p, input logic s);
    drive2(1'b0);
    for (int i = 0; i < 8; i++) drive2(d[i]);
    drive2(p);
    drive2(s);
  endtask

  task automatic frame2(input string tag, input logic [7:0] d, input logic p, input logic s);
    check({tag, "_data"}, dout2, d);
    check({tag, "_perr"}, perr2, model_perr(d, p));
    check({tag, "_serr"}, serr2, !s);
  endtask

  initial begin
    logic [7:0]  d;
    logic        p, s;
    int unsigned t0, gap;

    rst = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data1", dout1, 8'h00);
    check("rst_perr1", perr1, 1'b0);
    check("rst_serr1", serr1, 1'b0);
    check("rst_data4", dout2, 8'h00);

    send1(8'hD6, 1'b1, 1'b1);
    frame1("nominal", 8'hD6, 1'b1, 1'b1);
    drive1(1'b1);
`ifdef UART_RX_VALID_EN
    check("valid_drop", valid1, 1'b0);
`endif

    send1(8'hD6, 1'b0, 1'b1);
    frame1("parity_err", 8'hD6, 1'b0, 1'b1);
    drive1(1'b1);

    send1(8'h00, 1'b0, 1'b0);
    frame1("framing_err", 8'h00, 1'b0, 1'b0);
    drive1(1'b1);

    send1(8'h01, 1'b1, 1'b1);
    frame1("b2b_a", 8'h01, 1'b1, 1'b1);
    t0 = cyc;
    send1(8'h80, 1'b1, 1'b1);
    check("b2b_hold", dout1, 8'h01);
    frame1("b2b_b", 8'h80, 1'b1, 1'b1);
    check("b2b_gap", cyc - t0, 32'd11);
    drive1(1'b1);

    // Reset lands on data bit 4 of an 8'hFF frame.
    drive1(1'b0);
    for (int i = 0; i < 4; i++) drive1(1'b1);
    @(negedge clk);
    rx1 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", dout1, 8'h00);
    check("midrst_perr", perr1, 1'b0);
    check("midrst_serr", serr1, 1'b0);
    for (int i = 0; i < 4; i++) drive1(1'b1);
    check("midrst_nopartial", dout1, 8'h00);
    send1(8'h5A, 1'b0, 1'b1);
    check("midrst_hold", dout1, 8'h00);
    frame1("after_rst", 8'h5A, 1'b0, 1'b1);
    drive1(1'b1);

    for (int k = 0; k < 20; k++) begin
      d   = 8'($urandom);
      p   = 1'($urandom);
      s   = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      send1(d, p, s);
      frame1("rand1", d, p, s);
      for (int g = 0; g < int'(gap); g++) drive1(1'b1);
      if (gap != 0) check("rand1_hold", dout1, d);
    end

    // Four clocks per bit: single-cycle low glitch must be rejected.
    @(negedge clk);
    rx2 = 1'b0;
    @(negedge clk);
    rx2 = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_data", dout2, 8'h00);
    check("glitch_perr", perr2, 1'b0);
    check("glitch_serr", serr2, 1'b0);

    send2(8'h3C, 1'b0, 1'b1);
    frame2("cpb4", 8'h3C, 1'b0, 1'b1);
    drive2(1'b1);

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      send2(d, p, 1'b1);
      frame2("rand4", d, p, 1'b1);
      drive2(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
